// File: rtl/load_extend_unit.sv
// Load path between MEM and the data-cache port: aligns and extends read data.
// Define LOAD_MISALIGNED_SPLIT_EN to service misaligned loads with two reads.
module load_extend_unit #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32,
    parameter int RD_W   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [3:0]        req_sel,
    input  logic [RD_W-1:0]   req_rd,
    input  logic              flush,
    output logic              mem_read,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_resp,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [XLEN-1:0]   wb_data,
    output logic [RD_W-1:0]   wb_rd,
    output logic              misalign_err
);

    localparam int NB = XLEN / 8;
    localparam int OW = $clog2(NB);

    localparam logic [3:0] SEL_LW  = 4'b0011;
    localparam logic [3:0] SEL_LB  = 4'b0101;
    localparam logic [3:0] SEL_LBU = 4'b0110;
    localparam logic [3:0] SEL_LH  = 4'b0111;
    localparam logic [3:0] SEL_LHU = 4'b1000;
    localparam logic [3:0] SEL_LWU = 4'b1001;
    localparam logic [3:0] SEL_LD  = 4'b1010;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_HOLD,
`ifdef LOAD_MISALIGNED_SPLIT_EN
        S_ERR,
        S_REQ2
`else
        S_ERR
`endif
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [OW-1:0]     off_q, off_d;
    logic [3:0]        sel_q, sel_d;
    logic [RD_W-1:0]   rd_q, rd_d;
    logic [XLEN-1:0]   data_q, data_d;
    logic              flush_q, flush_d;
`ifdef LOAD_MISALIGNED_SPLIT_EN
    logic [XLEN-1:0]   beat_q, beat_d;
    logic              two_q, two_d;
`endif

    logic [OW-1:0]     req_off;
    logic              legal, misal, fail;
    logic [2*XLEN-1:0] wide;
    logic [XLEN-1:0]   sh, ext;

    assign req_off = req_addr[OW-1:0];

    always_comb begin
        legal = 1'b1;
        misal = 1'b0;
        case (req_sel)
            SEL_LB, SEL_LBU: misal = 1'b0;
            SEL_LH, SEL_LHU: misal = req_off[0];
            SEL_LW:          misal = |req_off[1:0];
            SEL_LWU: begin
                legal = (XLEN == 64);
                misal = |req_off[1:0];
            end
            SEL_LD: begin
                legal = (XLEN == 64);
                misal = |req_off;
            end
            default:         legal = 1'b0;
        endcase
    end

`ifdef LOAD_MISALIGNED_SPLIT_EN
    assign fail = !legal;
    assign wide = (state_q == S_REQ2) ? {mem_rdata, beat_q}
                                      : {{XLEN{1'b0}}, mem_rdata};
`else
    assign fail = !legal || misal;
    assign wide = {{XLEN{1'b0}}, mem_rdata};
`endif

    assign sh = XLEN'(wide >> {off_q, 3'b000});

    always_comb begin
        ext = sh;
        case (sel_q)
            SEL_LB:  ext = XLEN'(signed'(sh[7:0]));
            SEL_LBU: ext = XLEN'(sh[7:0]);
            SEL_LH:  ext = XLEN'(signed'(sh[15:0]));
            SEL_LHU: ext = XLEN'(sh[15:0]);
            SEL_LW:  ext = XLEN'(signed'(sh[31:0]));
            SEL_LWU: ext = XLEN'(sh[31:0]);
            default: ext = sh;
        endcase
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        off_d   = off_q;
        sel_d   = sel_q;
        rd_d    = rd_q;
        data_d  = data_q;
        flush_d = flush_q;
`ifdef LOAD_MISALIGNED_SPLIT_EN
        beat_d  = beat_q;
        two_d   = two_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req_valid && !flush) begin
                    addr_d  = {req_addr[ADDR_W-1:OW], {OW{1'b0}}};
                    off_d   = req_off;
                    sel_d   = req_sel;
                    rd_d    = req_rd;
                    flush_d = 1'b0;
`ifdef LOAD_MISALIGNED_SPLIT_EN
                    two_d   = misal;
`endif
                    state_d = fail ? S_ERR : S_REQ;
                end
            end
            S_REQ: begin
                if (flush) flush_d = 1'b1;
                if (mem_resp) begin
                    // A squashed load still drains its beat, then drops it
                    if (flush || flush_q) begin
                        state_d = S_IDLE;
`ifdef LOAD_MISALIGNED_SPLIT_EN
                    end else if (two_q) begin
                        beat_d  = mem_rdata;
                        state_d = S_REQ2;
`endif
                    end else begin
                        data_d  = ext;
                        state_d = S_HOLD;
                    end
                end
            end
`ifdef LOAD_MISALIGNED_SPLIT_EN
            S_REQ2: begin
                if (flush) flush_d = 1'b1;
                if (mem_resp) begin
                    if (flush || flush_q) begin
                        state_d = S_IDLE;
                    end else begin
                        data_d  = ext;
                        state_d = S_HOLD;
                    end
                end
            end
`endif
            S_HOLD: begin
                if (wb_ready || flush) state_d = S_IDLE;
            end
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            off_q   <= '0;
            sel_q   <= '0;
            rd_q    <= '0;
            data_q  <= '0;
            flush_q <= 1'b0;
`ifdef LOAD_MISALIGNED_SPLIT_EN
            beat_q  <= '0;
            two_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            off_q   <= off_d;
            sel_q   <= sel_d;
            rd_q    <= rd_d;
            data_q  <= data_d;
            flush_q <= flush_d;
`ifdef LOAD_MISALIGNED_SPLIT_EN
            beat_q  <= beat_d;
            two_q   <= two_d;
`endif
        end
    end

    assign req_ready    = (state_q == S_IDLE);
    assign wb_valid     = (state_q == S_HOLD);
    assign misalign_err = (state_q == S_ERR);
    assign wb_data      = data_q;
    assign wb_rd        = rd_q;

`ifdef LOAD_MISALIGNED_SPLIT_EN
    assign mem_read = (state_q == S_REQ) || (state_q == S_REQ2);
    assign mem_addr = (state_q == S_REQ2) ? addr_q + ADDR_W'(NB) : addr_q;
`else
    assign mem_read = (state_q == S_REQ);
    assign mem_addr = addr_q;
`endif

endmodule
